// File: rtl/decode_pipe_hs.sv
// ID->EX pipeline stage with valid/ready handshake, optional skid entry,
// RV32E register-range checking and a latched illegal-instruction trap record.
module decode_pipe_hs #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [31:0]       id_instr,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_r1,
    input  logic [XLEN-1:0]   id_r2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_r1,
    output logic [XLEN-1:0]   ex_r2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [4:0]        ex_rd,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic              exc_valid,
    output logic [4:0]        exc_cause,
    output logic [31:0]       exc_mtval,
    output logic [XLEN-1:0]   exc_pc,
    input  logic              exc_ack
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [4:0] CAUSE_ILLEGAL = 5'd2;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   r1;
        logic [XLEN-1:0]   r2;
        logic [XLEN-1:0]   imm;
        logic [CTRL_W-1:0] ctrl;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state;
    entry_t mainQ, skidQ, newEntry;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       opOk, useRd, useRs1, useRs2, regBad, illegal, isBubble;
    logic       accept, accLegal, accIllegal, drain;

    assign opc = id_instr[6:0];
    assign f3  = id_instr[14:12];
    assign f7  = id_instr[31:25];

    assign newEntry = '{pc: id_pc, r1: id_r1, r2: id_r2, imm: id_imm, ctrl: id_ctrl,
                        rd: id_instr[11:7], rs1: id_instr[19:15], rs2: id_instr[24:20]};

    // Opcode/funct legality and which register fields the format actually uses.
    always_comb begin
        opOk   = 1'b0;
        useRd  = 1'b0;
        useRs1 = 1'b0;
        useRs2 = 1'b0;
        case (opc)
            OPC_OP: begin
                opOk   = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
                useRd  = 1'b1;
                useRs1 = 1'b1;
                useRs2 = 1'b1;
            end
            OPC_OPIMM: begin
                if (f3 == 3'b001)      opOk = (f7 == 7'h00);
                else if (f3 == 3'b101) opOk = (f7 == 7'h00) || (f7 == 7'h20);
                else                   opOk = 1'b1;
                useRd  = 1'b1;
                useRs1 = 1'b1;
            end
            OPC_BRANCH: begin
                opOk   = (f3 != 3'b010) && (f3 != 3'b011);
                useRs1 = 1'b1;
                useRs2 = 1'b1;
            end
            OPC_JALR, OPC_SYSTEM: begin
                opOk   = 1'b1;
                useRd  = 1'b1;
                useRs1 = 1'b1;
            end
            OPC_JAL, OPC_AUIPC, OPC_LUI: begin
                opOk  = 1'b1;
                useRd = 1'b1;
            end
            OPC_LOAD: begin
                opOk   = (f3 != 3'b011) && (f3 < 3'b110);
                useRd  = 1'b1;
                useRs1 = 1'b1;
            end
            OPC_STORE: begin
                opOk   = (f3 <= 3'b010);
                useRs1 = 1'b1;
                useRs2 = 1'b1;
            end
            default: opOk = 1'b0;
        endcase
    end

    assign regBad = (NREGS == 32'd16) &&
                    ((useRd && id_instr[11]) || (useRs1 && id_instr[19]) || (useRs2 && id_instr[24]));
    assign illegal  = !opOk || regBad;
    assign isBubble = (id_instr == 32'd0);

    assign ex_valid = (state != EMPTY);
    assign drain    = ex_valid && ex_ready;

    generate
        if (SKID != 0) begin : g_skid
            assign id_ready = (state != TWO) && !exc_valid;
        end else begin : g_noskid
            assign id_ready = (!ex_valid || ex_ready) && !exc_valid;
        end
    endgenerate

    assign accept     = id_valid && id_ready;
    assign accLegal   = accept && !flush && !isBubble && !illegal;
    assign accIllegal = accept && !flush && !isBubble && illegal;

    assign ex_pc   = mainQ.pc;
    assign ex_r1   = mainQ.r1;
    assign ex_r2   = mainQ.r2;
    assign ex_imm  = mainQ.imm;
    assign ex_ctrl = mainQ.ctrl;
    assign ex_rd   = mainQ.rd;
    assign ex_rs1  = mainQ.rs1;
    assign ex_rs2  = mainQ.rs2;

    // Buffer state machine plus the trap record.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= EMPTY;
            mainQ     <= '0;
            skidQ     <= '0;
            exc_valid <= 1'b0;
            exc_cause <= 5'd0;
            exc_mtval <= 32'd0;
            exc_pc    <= '0;
        end else begin
            if (flush) begin
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY: if (accLegal) begin
                        mainQ <= newEntry;
                        state <= ONE;
                    end
                    ONE: begin
                        if (drain && accLegal) begin
                            mainQ <= newEntry;
                        end else if (drain) begin
                            state <= EMPTY;
                        end else if (accLegal) begin
                            skidQ <= newEntry;
                            state <= TWO;
                        end
                    end
                    TWO: if (drain) begin
                        mainQ <= skidQ;
                        state <= ONE;
                    end
                    default: state <= EMPTY;
                endcase
            end

            if (accIllegal) begin
                exc_valid <= 1'b1;
                exc_cause <= CAUSE_ILLEGAL;
                exc_mtval <= id_instr;
                exc_pc    <= id_pc;
            end else if (exc_ack && exc_valid) begin
                exc_valid <= 1'b0;
                exc_cause <= 5'd0;
                exc_mtval <= 32'd0;
                exc_pc    <= '0;
            end
        end
    end

endmodule

// File: doc/decode_pipe_hs.md
# decode_pipe_hs

Parametrised ID→EX pipeline stage for the pentaRV core, placed between the decode logic (control, immediate generator, register file) and the execute stage. It generalises the fixed decode pipeline register with a valid/ready handshake and an optional one-entry skid buffer. It also adds configurable data and control widths, RV32E register-range checking, and a latched, acknowledge-cleared illegal-instruction trap record.

## Interface
Parameters:
- XLEN, 32: data and PC width.
- CTRL_W, 16: width of the packed control bundle from Control.
- NREGS, 32: architectural register count; only 16 (RV32E) or 32 are legal.
- SKID, 1: 1 gives a registered `id_ready` with a 2-entry buffer; 0 gives a single entry with combinational ready.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all buffered entries.
- id_valid  in  1  decode presents an instruction.
- id_ready  out  1  stage can accept this cycle.
- id_instr  in  32  raw instruction.
- id_pc, id_r1, id_r2, id_imm  in  XLEN each  PC, operands, immediate.
- id_ctrl  in  CTRL_W  control bundle.
- ex_valid  out  1  execute entry valid.
- ex_ready  in  1  execute consumes this cycle.
- ex_pc, ex_r1, ex_r2, ex_imm  out  XLEN each  registered copies.
- ex_ctrl  out  CTRL_W  registered control.
- ex_rd, ex_rs1, ex_rs2  out  5 each  instr[11:7], [19:15], [24:20].
- exc_valid  out  1  illegal-instruction trap pending.
- exc_cause  out  5  trap cause; 2 = illegal instruction.
- exc_mtval  out  32  offending instruction word.
- exc_pc  out  XLEN  PC of offending instruction.
- exc_ack  in  1  trap consumer clears the record.

## Operation
- Accept occurs when `id_valid && id_ready`. Each accepted word is classified exactly once: bubble, legal, or illegal.
- Bubble: `id_instr == 0`. The word is consumed, nothing is enqueued, and no exception is raised.
- Illegal if any of the following hold:
  - The opcode is not one of OP, OP-IMM, BRANCH, JALR, JAL, AUIPC, LUI, LOAD, STORE, SYSTEM.
  - BRANCH with funct3 010 or 011.
  - LOAD with funct3 011, 110 or 111.
  - STORE with funct3 > 010.
  - OP with funct7 ∉ {0x00, 0x20}.
  - OP with funct7 = 0x20 and funct3 ∉ {000, 101}.
  - OP-IMM with funct3 001 and funct7 ≠ 0x00.
  - OP-IMM with funct3 101 and funct7 ∉ {0x00, 0x20}.
  - NREGS = 16 and bit 4 is set in any used register field:
    - rd: all formats except BRANCH and STORE.
    - rs1: all formats except LUI, AUIPC and JAL.
    - rs2: OP, BRANCH and STORE.
- Illegal word handling:
  - It is consumed but not enqueued.
  - Next edge: `exc_valid=1`, `exc_cause=2`, `exc_mtval=id_instr`, `exc_pc=id_pc`.
  - The record holds until `exc_ack`. While `exc_valid=1`, `id_ready=0`.
- Legal word: enqueued with all fields. `ex_*` presents the oldest entry, and order is strictly FIFO.
- SKID = 1: buffer state machine with a main and a skid register.
  - EMPTY → ONE on accept.
  - ONE → EMPTY on drain without accept; ONE → ONE on drain with accept.
  - ONE → TWO on accept without drain; the new entry goes to skid.
  - TWO → ONE on drain; skid moves to main.
  - `id_ready = (state != TWO) && !exc_valid`, taken from registers only.
- SKID = 0: single main register; `id_ready = (!ex_valid || ex_ready) && !exc_valid`.
- Drain means `ex_valid && ex_ready`.
- Flush:
  - Next state is EMPTY and `ex_valid=0`.
  - Any same-cycle accept is discarded and is not trap-checked.
  - The exception record is unaffected.
- `exc_ack`: clears `exc_valid` next edge; the cause, mtval and PC fields clear to 0.
- `exc_ack` while `exc_valid=0` is ignored.
- `exc_ack` together with `flush` applies both.

## Timing
- Reset (rst low, asynchronous):
  - State EMPTY; `ex_valid=0`; all `ex_*` data, control and index outputs 0.
  - `exc_valid=0`, `exc_cause=0`, `exc_mtval=0`, `exc_pc=0`; `id_ready=1`.
- Reset mid-transfer drops buffered entries and any pending trap.
- Latency: accept at edge N gives `ex_valid` after edge N and an illegal trap after edge N.
- Throughput: one accept per cycle while `ex_ready=1`.
- With SKID=1, `ex_ready` low for one cycle costs no bubble; the skid entry absorbs it.
- Payload stays stable while `ex_valid && !ex_ready`.
- An illegal word accepted in the same cycle as a drain does not disturb the drain.

## Test plan
- Back-to-back: ADDI x1,x0,5 (0x00500093) then ADD x2,x1,x1 (0x00108133) with `ex_ready=1` -> `ex_valid` on consecutive cycles, `ex_rd`=1 then 2, no gaps.
- Stall, SKID=1: three legal words with `ex_ready` held low for 2 cycles ->
  - state TWO and `id_ready=0` after the second accept;
  - after release, outputs appear in order with the third accepted on release.
- Illegal opcode 0x0000007F at PC 0x40 ->
  - no `ex_valid`; next cycle `exc_valid=1`, `exc_cause=2`, `exc_mtval=0x0000007F`, `exc_pc=0x40`, `id_ready=0`;
  - `exc_ack` clears it after one edge.
- NREGS=16: ADD x17,x1,x2 (0x002088B3) -> trap with mtval 0x002088B3; same word with NREGS=32 -> legal, `ex_rd`=17.
- Flush while state TWO plus same-cycle accept of an illegal word -> `ex_valid=0`, state EMPTY, `exc_valid` stays 0.
- Bubble 0x00000000, then assert rst low mid-stall -> bubble produces no `ex_valid`; reset gives all outputs 0 and `id_ready=1` immediately.
